// File: rtl/program_loader_if.sv
// Host/loader bundle: UART byte path, instruction-memory write port, and the core control outputs.
// The slave modport is the loader; the master modport is its environment (UART, BRAM, core).
interface program_loader_if #(
    parameter int INST_SIZE = 10
);
    logic                 load_req;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ferr;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 imem_we;
    logic [INST_SIZE-1:0] imem_addr;
    logic [31:0]          imem_wdata;
    logic [2:0]           mode;
    logic                 core_start;
    logic [INST_SIZE:0]   word_count;
    logic                 err;

    modport slave (
        input  load_req, rx_data, rx_valid, rx_ferr, tx_busy,
        output tx_data, tx_start, imem_we, imem_addr, imem_wdata,
               mode, core_start, word_count, err
    );

    modport master (
        output load_req, rx_data, rx_valid, rx_ferr, tx_busy,
        input  tx_data, tx_start, imem_we, imem_addr, imem_wdata,
               mode, core_start, word_count, err
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: sync with host over UART, stream a big-endian sized program into imem, then start the core.
// Writes land one cycle after the 4th byte of a word; an rx byte may arrive every cycle with no loss, tx waits on tx_busy.
module program_loader #(
    parameter int         INST_SIZE = 10,
    parameter logic [7:0] SYNC_BYTE = 8'hAA,
    parameter bit         AUTO_LOAD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SEND_SYNC, S_TX_WAIT, S_RECV_SIZE,
        S_RECV_WORD, S_SEND_ACK, S_EXEC, S_ERROR
    } state_t;

    localparam logic [2:0]  M_IDLE  = 3'd0;
    localparam logic [2:0]  M_LOAD  = 3'd1;
    localparam logic [2:0]  M_EXEC  = 3'd2;
    localparam logic [2:0]  M_ERROR = 3'd3;
    localparam logic [31:0] CAP     = 32'd1 << INST_SIZE;

    state_t               state_q;
    logic                 guard_q;
    logic                 ack_q;
    logic [1:0]           bcnt_q;
    logic [23:0]          shift_q;
    logic [INST_SIZE:0]   idx_q;
    logic [INST_SIZE:0]   word_count_q;
    logic [7:0]           tx_data_q;
    logic                 tx_start_q;
    logic                 imem_we_q;
    logic [INST_SIZE-1:0] imem_addr_q;
    logic [31:0]          imem_wdata_q;
    logic [2:0]           mode_q;
    logic                 core_start_q;
    logic                 err_q;

    logic [31:0]          word_d;
    logic [INST_SIZE:0]   idx_d;

    // The incoming byte completes the word combinationally, so the write can issue on the next edge.
    assign word_d = {shift_q, bus.rx_data};
    assign idx_d  = idx_q + (INST_SIZE+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            guard_q      <= 1'b0;
            ack_q        <= 1'b0;
            bcnt_q       <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            word_count_q <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            mode_q       <= M_IDLE;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            tx_start_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_EXEC, S_ERROR: begin
                    if ((state_q == S_IDLE && AUTO_LOAD) || bus.load_req) begin
                        state_q <= S_SEND_SYNC;
                        mode_q  <= M_LOAD;
                        err_q   <= 1'b0;
                        bcnt_q  <= '0;
                        idx_q   <= '0;
                    end
                end
                S_SEND_SYNC, S_SEND_ACK: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= SYNC_BYTE;
                        tx_start_q <= 1'b1;
                        guard_q    <= 1'b1;
                        ack_q      <= (state_q == S_SEND_ACK);
                        state_q    <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    // uart_tx raises busy a cycle after the strobe, so skip the first sample.
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (!bus.tx_busy) begin
                        if (ack_q) begin
                            state_q      <= S_EXEC;
                            mode_q       <= M_EXEC;
                            core_start_q <= 1'b1;
                        end else begin
                            state_q <= S_RECV_SIZE;
                        end
                    end
                end
                S_RECV_SIZE, S_RECV_WORD: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_ferr) begin
                            state_q <= S_ERROR;
                            mode_q  <= M_ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            shift_q <= word_d[23:0];
                            bcnt_q  <= bcnt_q + 2'd1;
                            if (bcnt_q == 2'd3 && state_q == S_RECV_SIZE) begin
                                if (word_d > CAP) begin
                                    state_q <= S_ERROR;
                                    mode_q  <= M_ERROR;
                                    err_q   <= 1'b1;
                                end else begin
                                    word_count_q <= word_d[INST_SIZE:0];
                                    state_q      <= (word_d == 32'd0) ? S_SEND_ACK : S_RECV_WORD;
                                end
                            end else if (bcnt_q == 2'd3) begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= idx_q[INST_SIZE-1:0];
                                imem_wdata_q <= word_d;
                                idx_q        <= idx_d;
                                if (idx_d == word_count_q) begin
                                    state_q <= S_SEND_ACK;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    mode_q  <= M_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.mode       = mode_q;
    assign bus.core_start = core_start_q;
    assign bus.word_count = word_count_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized host model driving the loader, with a queue scoreboard checked by an independent monitor.
module tb_program_loader;
    localparam int IS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    program_loader_if #(.INST_SIZE(IS)) bus();

    program_loader #(.INST_SIZE(IS), .SYNC_BYTE(8'hAA), .AUTO_LOAD(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [IS-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    logic [7:0]    exp_tx_q[$];
    logic [31:0]   fixed_q[$];
    int            exp_cs    = 0;
    int            n_tx      = 0;
    int            n_we      = 0;
    int            n_cs      = 0;
    int            n_txdone  = 0;
    logic [IS-1:0] last_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe.
    initial begin
        logic [IS-1:0] a;
        logic [31:0]   d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.tx_start) begin
                    n_tx++;
                    if (exp_tx_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_tx: got %0h expected no transmit", bus.tx_data);
                    end else begin
                        chk("tx_data", bus.tx_data, exp_tx_q.pop_front());
                        chk("tx_mode", bus.mode, 1);
                    end
                end
                if (bus.imem_we) begin
                    n_we++;
                    if (exp_addr_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.imem_addr, bus.imem_wdata);
                    end else begin
                        a = exp_addr_q.pop_front();
                        d = exp_data_q.pop_front();
                        chk("imem_addr", bus.imem_addr, a);
                        chk("imem_wdata", bus.imem_wdata, d);
                        last_addr = a;
                    end
                end else begin
                    chk("addr_hold", bus.imem_addr, last_addr);
                end
                if (bus.core_start) begin
                    n_cs++;
                    if (exp_cs == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_core_start: got pulse expected none");
                    end else begin
                        exp_cs--;
                        chk("cs_mode", bus.mode, 2);
                    end
                end
            end
        end
    end

    // uart_tx stand-in: busy for a random span after each strobe.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.tx_start) begin
                @(posedge clk); #1;
                bus.tx_busy = 1'b1;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
                bus.tx_busy = 1'b0;
                n_txdone++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe, input int gap);
        repeat (gap) tick();
        bus.rx_data  = b;
        bus.rx_ferr  = fe;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
    endtask

    task automatic wait_tx(input int target, input int budget);
        int c = 0;
        while (n_tx < target && c < budget) begin tick(); c++; end
        total++;
        if (n_tx < target) begin
            bad++;
            $display("FAIL tx_timeout: got %0d strobes expected %0d", n_tx, target);
        end
    endtask

    task automatic wait_txdone(input int target, input int budget);
        int c = 0;
        while (n_txdone < target && c < budget) begin tick(); c++; end
        total++;
        if (n_txdone < target) begin
            bad++;
            $display("FAIL busy_timeout: got %0d completions expected %0d", n_txdone, target);
        end
    endtask

    task automatic wait_cs(input int target, input int budget);
        int c = 0;
        while (n_cs < target && c < budget) begin tick(); c++; end
        total++;
        if (n_cs < target) begin
            bad++;
            $display("FAIL core_start_timeout: got %0d pulses expected %0d", n_cs, target);
        end
    endtask

    task automatic sync_handshake(input int budget);
        int t_tx = n_tx + 1;
        int t_d  = n_txdone + 1;
        wait_tx(t_tx, budget);
        wait_txdone(t_d, 30);
        repeat (2) tick();
    endtask

    task automatic reload();
        exp_tx_q.push_back(8'hAA);
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        sync_handshake(20);
        chk("reload_mode", bus.mode, 1);
        chk("reload_err", bus.err, 0);
    endtask

    // Host-side transfer; the expected outcome follows directly from N and the error position.
    task automatic do_load(input logic [31:0] n, input int fe_word, input int fe_byte,
                           input int maxgap, input bit lr_mid);
        logic [31:0] w;
        bit ok   = (n <= 32'd1024) && (fe_word < 0);
        int t_cs = n_cs + 1;
        if (ok) begin
            exp_tx_q.push_back(8'hAA);
            exp_cs++;
        end
        for (int i = 0; i < 4; i++) send_byte(n[31-8*i -: 8], 1'b0, $urandom_range(0, maxgap));
        if (n <= 32'd1024) begin
            for (int wi = 0; wi < n; wi++) begin
                w = (fixed_q.size() > 0) ? fixed_q.pop_front() : $urandom;
                if (wi == fe_word) begin
                    for (int b = 0; b < fe_byte; b++) send_byte(w[31-8*b -: 8], 1'b0, $urandom_range(0, maxgap));
                    send_byte(8'h5A, 1'b1, 0);
                    break;
                end
                exp_addr_q.push_back(wi[IS-1:0]);
                exp_data_q.push_back(w);
                if (lr_mid && wi == 0) bus.load_req = 1'b1;
                for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], 1'b0, $urandom_range(0, maxgap));
                bus.load_req = 1'b0;
            end
        end
        if (ok) begin
            wait_cs(t_cs, 100);
            tick();
            chk("exec_mode", bus.mode, 2);
            chk("word_count", bus.word_count, n[IS:0]);
            chk("exec_err", bus.err, 0);
        end else begin
            repeat (3) tick();
            chk("error_mode", bus.mode, 3);
            chk("error_flag", bus.err, 1);
        end
        chk("writes_drained", exp_addr_q.size(), 0);
        chk("tx_drained", exp_tx_q.size(), 0);
        chk("cs_drained", exp_cs, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_start"}, bus.tx_start, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
        chk({tag, "_imem_we"}, bus.imem_we, 0);
        chk({tag, "_imem_addr"}, bus.imem_addr, 0);
        chk({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        chk({tag, "_mode"}, bus.mode, 0);
        chk({tag, "_core_start"}, bus.core_start, 0);
        chk({tag, "_word_count"}, bus.word_count, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        int n;
        int fw;
        bus.load_req = 1'b0;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.rx_ferr  = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");

        exp_tx_q.push_back(8'hAA);
        rst = 1'b0;
        sync_handshake(3);
        chk("boot_mode", bus.mode, 1);

        fixed_q.push_back(32'h20080005);
        fixed_q.push_back(32'h8C090000);
        do_load(32'd2, -1, 0, 2, 1'b0);

        reload();
        do_load(32'd1025, -1, 0, 1, 1'b0);
        reload();
        do_load(32'd0, -1, 0, 1, 1'b0);

        reload();
        do_load(32'd2, 0, 2, 1, 1'b0);

        reload();
        do_load(32'd3, -1, 0, 0, 1'b1);
        send_byte(8'h11, 1'b0, 0);
        repeat (3) tick();
        chk("stray_rx_mode", bus.mode, 2);

        for (int it = 0; it < 6; it++) begin
            reload();
            n  = $urandom_range(1, 12);
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            do_load(n, fw, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        reload();
        do_load(32'd1024, -1, 0, 0, 1'b0);

        reload();
        exp_addr_q.push_back('0);
        exp_data_q.push_back(32'hCAFEF00D);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        send_byte(8'hCA, 1'b0, 0);
        send_byte(8'hFE, 1'b0, 0);
        send_byte(8'hF0, 1'b0, 0);
        send_byte(8'h0D, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        chk("pre_reset_writes", exp_addr_q.size(), 0);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_tx_q.delete();
        exp_cs    = 0;
        last_addr = '0;
        repeat (2) tick();
        exp_tx_q.push_back(8'hAA);
        rst = 1'b0;
        sync_handshake(3);
        chk("rearm_mode", bus.mode, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot/load controller that sequences the core from reset into execution. It handshakes with the host over the UART byte interfaces and streams a program into instruction memory. It then hands control to the core by switching the global mode and pulsing a start strobe. It sits between uart_rx/uart_tx and the instruction BRAM write port, and drives the mode bus consumed by the execute stage.

Parameters:
INST_SIZE, 10, instruction memory address width in words; capacity is 2**INST_SIZE words
SYNC_BYTE, 8'hAA, byte sent to the host to request a program and byte sent to acknowledge completion
AUTO_LOAD, 1, when 1 a load starts automatically on reset release; when 0 the block waits for load_req

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load_req  in  1  request a (re)load; single-cycle pulse or level
rx_data  in  8  received byte from uart_rx
rx_valid  in  1  rx_data valid this cycle (1-cycle pulse per byte)
rx_ferr  in  1  framing error flag, qualified by rx_valid
tx_data  out  8  byte to uart_tx
tx_start  out  1  1-cycle transmit strobe
tx_busy  in  1  uart_tx busy
imem_we  out  1  instruction memory write enable
imem_addr  out  INST_SIZE  word address
imem_wdata  out  32  instruction word
mode  out  3  0 IDLE, 1 LOAD, 2 EXEC, 3 ERROR
core_start  out  1  1-cycle pulse on entry to EXEC
word_count  out  INST_SIZE+1  number of words announced by the host for the current load
err  out  1  high while in ERROR

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0: mode=0, tx_start=0, tx_data=0, imem_we=0, imem_addr=0, imem_wdata=0, core_start=0, word_count=0, err=0. Byte and word counters are cleared.
- Reset asserted mid-load aborts immediately; no further imem_we is issued.
- IDLE: go to SEND_SYNC on the first cycle after reset release if AUTO_LOAD=1, else on load_req.
- SEND_SYNC (mode=1): when tx_busy=0, drive tx_data=SYNC_BYTE and tx_start=1 for exactly 1 cycle, then go to TX_WAIT.
- TX_WAIT: ignore tx_busy for 1 guard cycle, then wait for tx_busy=0. Next state is RECV_SIZE after the sync byte, or EXEC after the ack byte.
- RECV_SIZE: assemble 4 bytes big-endian (first byte = bits 31:24) into N.
  - N > 2**INST_SIZE goes to ERROR.
  - N = 0 goes to SEND_ACK.
  - Otherwise word_count=N[INST_SIZE:0] and the block goes to RECV_WORD.
- RECV_WORD: assemble 4 bytes big-endian.
  - On the 4th byte, in the next cycle: imem_we=1 for 1 cycle, imem_addr=current word index, imem_wdata=assembled word.
  - Then the index increments.
  - When index reaches N, go to SEND_ACK; otherwise stay in RECV_WORD.
  - A byte arriving in the write cycle is accepted; assembly and write overlap, with no byte loss at back-to-back rx_valid.
- SEND_ACK: same as SEND_SYNC with tx_data=SYNC_BYTE, then TX_WAIT, then EXEC.
- EXEC (mode=2): core_start=1 in the first EXEC cycle only. load_req goes to SEND_SYNC (reload); the word index and byte counter are cleared.
- ERROR (mode=3, err=1): hold until rst or load_req; load_req clears err and goes to SEND_SYNC.
- rx_valid with rx_ferr=1 while in RECV_SIZE or RECV_WORD goes to ERROR; the byte is discarded.
- rx_valid in IDLE, SEND_*, TX_WAIT, EXEC or ERROR is ignored (dropped), with no state change.
- load_req during SEND_*, TX_WAIT or RECV_* is ignored.
- mode is registered and changes in the same cycle as the state register.
- imem_addr holds its last value when imem_we=0.

Test Plan:
1. AUTO_LOAD=1, release rst, tx_busy=0 -> tx_start pulses once with tx_data=8'hAA within 2 cycles; mode=1.
2. Host sends 00 00 00 02, 20 08 00 05, 8C 09 00 00 -> imem writes (0, 32'h20080005) then (1, 32'h8C090000); word_count=2. Then 8'hAA is sent, followed by mode=2 and a single core_start pulse.
3. Size bytes 00 00 04 01 with INST_SIZE=10 (1025 > 1024) -> mode=3, err=1, no imem_we. A later load_req clears err and re-sends 8'hAA.
4. Size 00 00 00 00 -> no imem_we, ack 8'hAA sent, EXEC entered.
5. rx_valid with rx_ferr=1 on the 3rd data byte -> ERROR with no partial write. rst asserted mid-word -> all outputs 0 asynchronously.
6. Back-to-back rx_valid every cycle for 3 words -> 3 writes at addresses 0,1,2 with correct data. In EXEC, load_req -> tx_start with 8'hAA and mode=1.
